// File: rtl/jseq_pkg.sv
// jseq_pkg: shared definitions for the Johnson sequencer.
//   - FSM state encodings (ST_IDLE / ST_RUN)
//   - step direction constants (DIR_FWD / DIR_REV)
//   - jseq_phase(): maps a ring code to its forward-sequence index, or -1
//     when the code is not a legal Johnson pattern for the given width.
package jseq_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // Index k in [0, width] is k ones filling from the LSB. Index k in
    // (width, 2*width) is ones in the top 2*width-k bits. The loop bound is
    // fixed so the function folds to a constant comparator tree when
    // width is a parameter.
    function automatic int jseq_phase(input logic [31:0] code, input int width);
        logic [31:0] mask;
        logic [31:0] pat;
        int          result;
        result = -1;
        mask   = (32'd1 << width) - 32'd1;
        for (int k = 0; k < 64; k++) begin
            if (k < 2 * width) begin
                if (k <= width) begin
                    pat = (32'd1 << k) - 32'd1;
                end else begin
                    pat = mask & ~((32'd1 << (k - width)) - 32'd1);
                end
                if (((code & mask) == pat) && (result < 0)) begin
                    result = k;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/johnson_core.sv
// johnson_core: Johnson ring register with a binary phase tracker.
// Ports:
//   clk      in   system clock, rising edge
//   clr_n    in   asynchronous active-low reset
//   en       in   advance the ring by one step this edge
//   dir      in   DIR_FWD shifts left, DIR_REV shifts right
//   sync_clr in   synchronous clear of ring and phase (wins over en)
//   q        out  ring state
//   phase    out  index of q in the forward sequence
module johnson_core
    import jseq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int PH_W  = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic             dir,
    input  logic             sync_clr,
    output logic [WIDTH-1:0] q,
    output logic [PH_W-1:0]  phase
);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * WIDTH - 1);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q     <= '0;
            phase <= '0;
        end else if (sync_clr) begin
            q     <= '0;
            phase <= '0;
        end else if (en) begin
            if (dir == DIR_FWD) begin
                q     <= {q[WIDTH-2:0], ~q[WIDTH-1]};
                phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
            end else begin
                q     <= {~q[0], q[WIDTH-1:1]};
                phase <= (phase == '0) ? PH_LAST : phase - 1'b1;
            end
        end
    end

endmodule

// File: rtl/johnson_seq_ctrl.sv
// johnson_seq_ctrl: runs a Johnson ring for a programmed number of steps.
// Optional feature macro: JSEQ_SELFCHECK_EN (illegal ring code checker;
// when undefined, err is tied low and no checker is built).
// Ports:
//   clk    in   system clock, rising edge
//   clr_n  in   asynchronous active-low reset
//   start  in   run request, sampled only in IDLE
//   stop   in   abort current run (beats hold)
//   hold   in   freeze stepping while in RUN
//   dir    in   step direction, latched on accepted start
//   steps  in   step count, latched on accepted start
//   q      out  ring state
//   phase  out  forward-sequence index of q
//   busy   out  high while in RUN
//   done   out  one-cycle pulse on normal completion
//   err    out  sticky illegal-code flag
//
// state   | meaning
// --------+----------------------------------------------
// ST_IDLE | waiting for start; steps=0 start pulses done
// ST_RUN  | stepping once per un-held edge until remaining hits 0
module johnson_seq_ctrl
    import jseq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter int PH_W  = $clog2(2 * WIDTH)  // derived, leave at default
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic             dir,
    input  logic [CNT_W-1:0] steps,
    output logic [WIDTH-1:0] q,
    output logic [PH_W-1:0]  phase,
    output logic             busy,
    output logic             done,
    output logic             err
);

    logic [0:0]       state;
    logic [CNT_W-1:0] remaining;
    logic             dir_q;
    logic             step_en;
    logic             illegal;

`ifdef JSEQ_SELFCHECK_EN
    logic err_q;

    assign illegal = (jseq_phase(32'(q), WIDTH) < 0);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            err_q <= 1'b0;
        end else if (illegal) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign illegal = 1'b0;
    assign err     = 1'b0;
`endif

    assign busy    = (state == ST_RUN);
    assign step_en = (state == ST_RUN) && !stop && !hold && !illegal;

    johnson_core #(
        .WIDTH (WIDTH),
        .PH_W  (PH_W)
    ) u_core (
        .clk      (clk),
        .clr_n    (clr_n),
        .en       (step_en),
        .dir      (dir_q),
        .sync_clr (illegal),
        .q        (q),
        .phase    (phase)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= ST_IDLE;
            remaining <= '0;
            dir_q     <= DIR_FWD;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                // A start is not taken while the ring is being scrubbed.
                if (start && !stop && !illegal) begin
                    if (steps != '0) begin
                        state     <= ST_RUN;
                        remaining <= steps;
                        dir_q     <= dir;
                    end else begin
                        done <= 1'b1;
                    end
                end
            end else begin
                if (illegal || stop) begin
                    state <= ST_IDLE;
                end else if (!hold) begin
                    remaining <= remaining - 1'b1;
                    if (remaining == CNT_W'(1)) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// tb_johnson_seq_ctrl: directed bench for johnson_seq_ctrl (WIDTH=4).
// Expected per-cycle outputs are queued when stimulus is applied and
// popped one edge later. Define JSEQ_SELFCHECK_EN to add the checker test.
module tb_johnson_seq_ctrl;
    import jseq_pkg::*;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       start, stop, hold, dir;
    logic [7:0] steps;
    logic [3:0] q;
    logic [2:0] phase;
    logic       busy, done, err;

    typedef struct {
        logic [3:0] q;
        logic [2:0] ph;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] mq;
    logic [2:0] mph;
    logic       m_err;
    int         n_run  = 0;
    int         n_fail = 0;

    johnson_seq_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .start (start),
        .stop  (stop),
        .hold  (hold),
        .dir   (dir),
        .steps (steps),
        .q     (q),
        .phase (phase),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic d);
        if (d == DIR_FWD) begin
            mq  = {mq[2:0], ~mq[3]};
            mph = (mph == 3'd7) ? 3'd0 : mph + 3'd1;
        end else begin
            mq  = {~mq[0], mq[3:1]};
            mph = (mph == 3'd0) ? 3'd7 : mph - 3'd1;
        end
    endtask

    task automatic push_exp(input logic b, input logic d);
        exp_t e;
        e.q = mq; e.ph = mph; e.busy = b; e.done = d;
        sb.push_back(e);
    endtask

    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        chk({tag, "/sb"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "/q"},     32'(q),     32'(e.q));
            chk({tag, "/phase"}, 32'(phase), 32'(e.ph));
            chk({tag, "/map"},   32'(phase), 32'(jseq_phase(32'(e.q), 4)));
            chk({tag, "/busy"},  32'(busy),  32'(e.busy));
            chk({tag, "/done"},  32'(done),  32'(e.done));
            chk({tag, "/err"},   32'(err),   32'(m_err));
        end
    endtask

    // Start a run of n steps; dir/steps are scrambled during RUN and start is
    // re-pulsed at step index poke_at to show both are ignored while busy.
    task automatic run(input string tag, input int n, input logic d, input int poke_at);
        start = 1'b1; steps = 8'(n); dir = d;
        push_exp(n != 0, n == 0);
        tick({tag, "/acc"});
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            start = (i == poke_at);
            dir   = ~d;
            steps = 8'hff;
            model_step(d);
            push_exp(i < n - 1, i == n - 1);
            tick({tag, "/step"});
        end
        start = 1'b0; dir = 1'b0; steps = 8'd0;
    endtask

    initial begin
        clr_n = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0; dir = 1'b0; steps = 8'd0;
        mq = 4'd0; mph = 3'd0; m_err = 1'b0;
        #12;
        chk("rst/q", 32'(q), 32'h0);
        chk("rst/phase", 32'(phase), 32'h0);
        chk("rst/busy", 32'(busy), 32'h0);
        chk("rst/done", 32'(done), 32'h0);
        chk("rst/err", 32'(err), 32'h0);
        clr_n = 1'b1;

        // Forward 5 steps from reset, then chain a start on the done cycle.
        run("t1", 5, 1'b0, -1);
        chk("t1/q_end", 32'(q), 32'b1110);
        chk("t1/ph_end", 32'(phase), 32'd5);
        run("t2a", 3, 1'b0, -1);
        chk("t2a/q_end", 32'(q), 32'b0000);
        run("t2b", 8, 1'b0, -1);
        chk("t2b/q_wrap", 32'(q), 32'b0000);
        chk("t2b/ph_wrap", 32'(phase), 32'd0);
        run("t2c", 3, 1'b1, -1);
        chk("t2c/q_end", 32'(q), 32'b1110);
        chk("t2c/ph_end", 32'(phase), 32'd5);
        run("t2d", 3, 1'b0, -1);

        // Hold for two cycles after the second step, stop on the fourth.
        start = 1'b1; steps = 8'd6; dir = 1'b0;
        push_exp(1'b1, 1'b0); tick("t3/acc");
        start = 1'b0;
        model_step(1'b0); push_exp(1'b1, 1'b0); tick("t3/s1");
        model_step(1'b0); push_exp(1'b1, 1'b0); tick("t3/s2");
        hold = 1'b1;
        push_exp(1'b1, 1'b0); tick("t3/h1");
        push_exp(1'b1, 1'b0); tick("t3/h2");
        hold = 1'b0;
        model_step(1'b0); push_exp(1'b1, 1'b0); tick("t3/s3");
        stop = 1'b1; hold = 1'b1;
        push_exp(1'b0, 1'b0); tick("t3/stop");
        stop = 1'b0; hold = 1'b0;
        push_exp(1'b0, 1'b0); tick("t3/idle");
        chk("t3/q_end", 32'(q), 32'b0111);
        chk("t3/ph_end", 32'(phase), 32'd3);

        // Zero-length run, idle-only controls, start+stop in IDLE.
        start = 1'b1; steps = 8'd0;
        push_exp(1'b0, 1'b1); tick("t4/zero");
        start = 1'b0;
        push_exp(1'b0, 1'b0); tick("t4/zero_after");
        stop = 1'b1; hold = 1'b1;
        push_exp(1'b0, 1'b0); tick("t4/idle_ctl");
        start = 1'b1; steps = 8'd4;
        push_exp(1'b0, 1'b0); tick("t4/start_stop");
        start = 1'b0; stop = 1'b0; hold = 1'b0;
        run("t4poke", 4, 1'b1, 1);
        chk("t4poke/q_end", 32'(q), 32'b1000);

        // Asynchronous reset in the middle of a run.
        start = 1'b1; steps = 8'd6; dir = 1'b0;
        push_exp(1'b1, 1'b0); tick("t5/acc");
        start = 1'b0;
        model_step(1'b0); push_exp(1'b1, 1'b0); tick("t5/s1");
        model_step(1'b0); push_exp(1'b1, 1'b0); tick("t5/s2");
        #1 clr_n = 1'b0;
        #1;
        chk("t5/async_q", 32'(q), 32'h0);
        chk("t5/async_phase", 32'(phase), 32'h0);
        chk("t5/async_busy", 32'(busy), 32'h0);
        chk("t5/async_done", 32'(done), 32'h0);
        #2 clr_n = 1'b1;
        mq = 4'd0; mph = 3'd0;
        push_exp(1'b0, 1'b0); tick("t5/after");
        run("t5b", 2, 1'b1, -1);
        chk("t5b/q_end", 32'(q), 32'b1100);

`ifdef JSEQ_SELFCHECK_EN
        // Corrupt the ring for one cycle during a run.
        start = 1'b1; steps = 8'd5; dir = 1'b0;
        push_exp(1'b1, 1'b0); tick("t6/acc");
        start = 1'b0;
        model_step(1'b0); push_exp(1'b1, 1'b0); tick("t6/s1");
        force dut.u_core.q = 4'b0101;
        #8;
        release dut.u_core.q;
        mq = 4'd0; mph = 3'd0; m_err = 1'b1;
        push_exp(1'b0, 1'b0); tick("t6/scrub");
        push_exp(1'b0, 1'b0); tick("t6/sticky");
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
